// File: rtl/axi4_lite_slave_mem.sv
// ============================================================================
// Module   : axi4_lite_slave_mem
// Brief    : AXI4-Lite responder for a word-addressed, byte-strobed memory.
//            Define AXI_SLAVE_MEM_SLVERR_EN to answer out-of-range accesses
//            with SLVERR instead of wrapping the address.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axi4_lite_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int NB    = DATA_WIDTH / 8;

    localparam logic [1:0] C_OKAY   = 2'b00;
    localparam logic [1:0] C_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_WAIT_DATA = 2'd1;
    localparam logic [1:0] W_WAIT_ADDR = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;

    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_VALID = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [1:0]            r_w_state;
    logic [1:0]            w_w_next;
    logic [0:0]            r_r_state;
    logic [0:0]            w_r_next;

    logic                  r_awready;
    logic                  r_wready;
    logic                  r_arready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [NB-1:0]         w_wr_strb;
    logic                  w_wr_oor;
    logic                  w_ar_oor;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_unused;

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_arready = r_arready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_rvalid  = r_rvalid;
    assign s_rresp   = r_rresp;
    assign s_rdata   = r_rdata;

    // Readies are registered, so handshakes only ever qualify on flopped state.
    assign w_aw_hs = s_awvalid & r_awready;
    assign w_w_hs  = s_wvalid  & r_wready;
    assign w_ar_hs = s_arvalid & r_arready;

    assign w_wr_idx = w_wr_addr[IDX_W+1:2];
    assign w_ar_idx = s_araddr[IDX_W+1:2];

`ifdef AXI_SLAVE_MEM_SLVERR_EN
    assign w_wr_oor = |w_wr_addr[ADDR_WIDTH-1:IDX_W+2];
    assign w_ar_oor = |s_araddr[ADDR_WIDTH-1:IDX_W+2];
    assign w_unused = ^{s_araddr[1:0], w_wr_addr[1:0]};
`else
    assign w_wr_oor = 1'b0;
    assign w_ar_oor = 1'b0;
    assign w_unused = ^{s_araddr[ADDR_WIDTH-1:IDX_W+2], s_araddr[1:0],
                        w_wr_addr[ADDR_WIDTH-1:IDX_W+2], w_wr_addr[1:0]};
`endif

    always_comb begin
        w_w_next  = r_w_state;
        w_wr_en   = 1'b0;
        w_wr_addr = s_awaddr;
        w_wr_data = s_wdata;
        w_wr_strb = s_wstrb;
        case (r_w_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wr_en  = 1'b1;
                    w_w_next = W_RESP;
                end else if (w_aw_hs) begin
                    w_w_next = W_WAIT_DATA;
                end else if (w_w_hs) begin
                    w_w_next = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                w_wr_addr = r_awaddr;
                if (w_w_hs) begin
                    w_wr_en  = 1'b1;
                    w_w_next = W_RESP;
                end
            end
            W_WAIT_ADDR: begin
                w_wr_data = r_wdata;
                w_wr_strb = r_wstrb;
                if (w_aw_hs) begin
                    w_wr_en  = 1'b1;
                    w_w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    w_w_next = W_IDLE;
                end
            end
            default: w_w_next = W_IDLE;
        endcase
    end

    always_comb begin
        w_r_next = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs)  w_r_next = R_VALID;
            R_VALID: if (s_rready) w_r_next = R_IDLE;
            default: w_r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_state <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= C_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_w_state <= w_w_next;
            r_awready <= (w_w_next == W_IDLE) || (w_w_next == W_WAIT_ADDR);
            r_wready  <= (w_w_next == W_IDLE) || (w_w_next == W_WAIT_DATA);
            r_bvalid  <= (w_w_next == W_RESP);
            if (w_aw_hs) begin
                r_awaddr <= s_awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= s_wdata;
                r_wstrb <= s_wstrb;
            end
            if (w_wr_en) begin
                r_bresp <= w_wr_oor ? C_SLVERR : C_OKAY;
            end
        end
    end

    // Storage is deliberately not reset; the read register samples the
    // pre-write contents when both channels hit the same word on one edge.
    always_ff @(posedge clk) begin
        if (w_wr_en && !w_wr_oor) begin
            for (int b = 0; b < NB; b++) begin
                if (w_wr_strb[b]) begin
                    r_mem[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r_state <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= C_OKAY;
            r_rdata   <= '0;
        end else begin
            r_r_state <= w_r_next;
            r_arready <= (w_r_next == R_IDLE);
            r_rvalid  <= (w_r_next == R_VALID);
            if (w_ar_hs) begin
                r_rdata <= w_ar_oor ? '0 : r_mem[w_ar_idx];
                r_rresp <= w_ar_oor ? C_SLVERR : C_OKAY;
            end
        end
    end

endmodule

`default_nettype wire
